reg_mask_encoder: RTL and testbench
===================================

# reg_mask_encoder

Serializes a 32-bit register mask into a stream of 5-bit register indices, lowest index first, one per accepted handshake. It is the inverse of the register-file 5-to-32 write-select decoder. It serves multi-register sequences such as context save/restore, scoreboard flush, and debug register dumps. A controller loads a mask; the block walks the set bits and presents each index on a valid/ready port until the mask is exhausted.

## Interface
Parameters:
- WIDTH, 32, mask width; one bit per architectural register.
- IDX_W, 5, index width; equals $clog2(WIDTH).

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- load_valid  in  1  a new mask is offered.
- load_ready  out  1  the block is idle and can accept a mask.
- load_mask  in  WIDTH  mask to serialize; bit i set means register i.
- idx_valid  out  1  idx holds a valid register index.
- idx_ready  in  1  the consumer accepts idx this cycle.
- idx  out  IDX_W  lowest set bit of the remaining mask.
- idx_last  out  1  the current idx is the final one of this mask.
- count  out  IDX_W+1  number of indices still to emit, including the current one.
- done  out  1  one-cycle pulse when a mask completes.

## Operation
- State machine has two states, IDLE and EMIT. Reset state is IDLE.
- load_ready = (state == IDLE). A load is accepted when load_valid && load_ready.
- **Non-zero mask accepted:**
  - The mask register takes the (possibly filtered) mask.
  - count takes the popcount of that mask.
  - The state becomes EMIT.
- **Zero mask accepted:**
  - The state stays IDLE and count stays 0.
  - done pulses in the next cycle. No index is emitted.
- **In EMIT:**
  - idx_valid = 1.
  - idx = index of the lowest set bit of the mask register.
  - idx_last = (count == 1).
- **Handshake (idx_valid && idx_ready):**
  - Clear the lowest set bit of the mask register.
  - Decrement count.
  - If idx_last, go to IDLE and pulse done in the following cycle.
- **Backpressure:** while idx_ready is low, idx, idx_last and count hold stable and idx_valid stays high. idx_valid is never withdrawn before a handshake.
- load_valid is ignored in EMIT; a mask can never be lost mid-sequence.
- Index ordering is strictly ascending and each set bit is emitted exactly once.
- **Reset values:**
  - load_ready = 1.
  - idx_valid = 0, idx = 0, idx_last = 0.
  - count = 0, done = 0.
  - Mask register = 0.

## Timing
- **Load to first index:** load accepted at edge N; idx_valid is high from cycle N+1.
- **Throughput:** with idx_ready held high, one index per cycle. A mask with k set bits completes in k cycles after cycle N+1.
- **done:** asserted for the one cycle after the final handshake edge. load_ready is also high in that cycle, so a back-to-back load is accepted there. No dead cycle between masks.
- **Output paths:** idx and idx_last are combinational from registered state only. No combinational path exists from load_* or idx_ready to any output.
- **Reset mid-emission:** rst_n low forces all outputs to reset values asynchronously. The pending mask is discarded and no done is generated.

## Configuration
- **MASK_R0_EN defined:** bit 0 of load_mask is forced to 0 before the mask is stored and counted, so register $zero is never emitted. A mask of 0x0000_0001 behaves as a zero mask.
- **MASK_R0_EN undefined:** all WIDTH bits are serialized unchanged.

## Structure
- **Shared package reg_enc_pkg:**
  - WIDTH, IDX_W.
  - State enum {IDLE, EMIT}.
  - Lowest-set-bit clear helper (mask & (mask - 1)).
- **Sub-module prio_enc32:** combinational lowest-set-bit priority encoder. It maps a WIDTH-bit vector to an IDX_W index plus a nonzero flag. It is instantiated once on the mask register.
- The top level holds the FSM, mask register, count register and done register.

## Test plan
- **Basic two-bit mask:** load 0x8000_0001, idx_ready=1 → idx 0, then idx 31 with idx_last=1; done pulses in the next cycle; count goes 2, 1, 0.
- **Full mask:** load 0xFFFF_FFFF, idx_ready=1 → idx 0..31 on 32 consecutive cycles; count starts at 32; idx_last only on idx 31.
- **Backpressure:** load 0x0000_0050, hold idx_ready=0 for 3 cycles → idx=4, idx_valid=1, count=2 stable throughout; after release, idx 4 then 6.
- **Zero mask:** load 0x0000_0000 → idx_valid never rises; done pulses at N+1; load_ready stays 1.
- **Load blocked and back-to-back load:** load_valid asserted during EMIT is not accepted. A new load in the done cycle starts the next mask with no gap.
- **Reset and configuration:** rst_n dropped after 2 of 5 indices → outputs immediately go to reset values, and no done follows. With MASK_R0_EN, load 0x0000_0003 → only idx 1 is emitted, count=1.

Source files
------------

// File: rtl/reg_mask_encoder_pkg.sv
// Shared types and helpers for the register-mask encoder.
// Defining MASK_R0_EN drops register 0 from every loaded mask.
package reg_enc_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [WIDTH-1:0] clear_lowest(input logic [WIDTH-1:0] m);
        return m & (m - WIDTH'(1));
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_mask_encoder_if.sv
// Load and index streams of the register-mask encoder.
// The master side is the controller and consumer; the slave side is the encoder.
interface reg_mask_encoder_if;
    import reg_enc_pkg::*;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_mask;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic [IDX_W:0]   count;
    logic             done;

    modport master (
        output load_valid, load_mask, idx_ready,
        input  load_ready, idx_valid, idx, idx_last, count, done
    );

    modport slave (
        input  load_valid, load_mask, idx_ready,
        output load_ready, idx_valid, idx, idx_last, count, done
    );

endinterface

// File: rtl/reg_mask_encoder_prio_enc32.sv
// Lowest-set-bit priority encoder; index is 0 when the vector is empty.
module prio_enc32 #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             nz_o
);

    always_comb begin
        idx_o = '0;
        nz_o  = |vec_i;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_mask_encoder.sv
// Walks the set bits of a loaded register mask and emits their indices, lowest first.
// Build option MASK_R0_EN: bit 0 of the loaded mask is ignored.
module reg_mask_encoder
    import reg_enc_pkg::*;
#(
    parameter int WIDTH = reg_enc_pkg::WIDTH,
    parameter int IDX_W = reg_enc_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_mask_encoder_if.slave   bus
);

    state_e           state_q;
    logic [WIDTH-1:0] mask_q;
    logic [IDX_W:0]   count_q;
    logic             done_q;

    logic [WIDTH-1:0] load_mask_f;
    logic [IDX_W-1:0] lsb_idx;
    logic             lsb_nz;
    logic             is_last;

`ifdef MASK_R0_EN
    assign load_mask_f = {bus.load_mask[WIDTH-1:1], 1'b0};
`else
    assign load_mask_f = bus.load_mask;
`endif

    prio_enc32 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio (
        .vec_i (mask_q),
        .idx_o (lsb_idx),
        .nz_o  (lsb_nz)
    );

    assign is_last = (count_q == {{IDX_W{1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        if (|load_mask_f) begin
                            mask_q  <= load_mask_f;
                            count_q <= popcount(load_mask_f);
                            state_q <= EMIT;
                        end else begin
                            // Empty mask completes immediately without emitting.
                            done_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.idx_ready) begin
                        mask_q  <= clear_lowest(mask_q);
                        count_q <= count_q - 1'b1;
                        if (is_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.idx_valid  = (state_q == EMIT) && lsb_nz;
    assign bus.idx        = lsb_idx;
    assign bus.idx_last   = (state_q == EMIT) && is_last;
    assign bus.count      = count_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Randomized bench for reg_mask_encoder against a queue-based index model.
module tb_reg_mask_encoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_mask_encoder_if bus();

    reg_mask_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".load_ready"}, 32'(bus.load_ready), 32'd1);
        check({tag, ".idx_valid"},  32'(bus.idx_valid),  32'd0);
        check({tag, ".idx"},        32'(bus.idx),        32'd0);
        check({tag, ".idx_last"},   32'(bus.idx_last),   32'd0);
        check({tag, ".count"},      32'(bus.count),      32'd0);
        check({tag, ".done"},       32'(bus.done),       32'd0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stalled for the first 3 cycles.
    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_mask(input logic [31:0] m, input int mode);
        int          q[$];
        logic [31:0] f;
        int          cyc;
        logic        rdy;
        f = m;
`ifdef MASK_R0_EN
        f[0] = 1'b0;
`endif
        for (int i = 0; i < 32; i++) begin
            if (f[i]) q.push_back(i);
        end
        check("load_ready_before_load", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_mask  = m;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_mask  = $urandom;
        if (q.size() == 0) begin
            check("zero.done",       32'(bus.done),       32'd1);
            check("zero.idx_valid",  32'(bus.idx_valid),  32'd0);
            check("zero.load_ready", 32'(bus.load_ready), 32'd1);
            check("zero.count",      32'(bus.count),      32'd0);
            @(negedge clk);
            check("zero.done_drop",  32'(bus.done),       32'd0);
            check("zero.idx_valid2", 32'(bus.idx_valid),  32'd0);
            return;
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            check("emit.idx_valid",  32'(bus.idx_valid),  32'd1);
            check("emit.idx",        32'(bus.idx),        32'(q[0]));
            check("emit.idx_last",   32'(bus.idx_last),   32'(q.size() == 1));
            check("emit.count",      32'(bus.count),      32'(q.size()));
            check("emit.done",       32'(bus.done),       32'd0);
            check("emit.load_ready", 32'(bus.load_ready), 32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 3);
            endcase
            bus.idx_ready  = rdy;
            // Offers during emission must be ignored.
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_mask  = $urandom;
            @(negedge clk);
            cyc++;
            if (rdy) void'(q.pop_front());
        end
        bus.load_valid = 1'b0;
        bus.idx_ready  = 1'b0;
        if (q.size() != 0) check("emit.timeout", 32'(q.size()), 32'd0);
        check("end.done",       32'(bus.done),       32'd1);
        check("end.idx_valid",  32'(bus.idx_valid),  32'd0);
        check("end.load_ready", 32'(bus.load_ready), 32'd1);
        check("end.count",      32'(bus.count),      32'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_mask  = '0;
        bus.idx_ready  = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        run_mask(32'h8000_0001, 0);
        run_mask(32'hFFFF_FFFF, 0);
        run_mask(32'h0000_0050, 2);
        run_mask(32'h0000_0000, 0);
        run_mask(32'h0000_0003, 0);
        run_mask(32'h0000_0001, 1);
        run_mask(32'h8000_0000, 2);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] m;
            case ($urandom_range(0, 3))
                0:       m = $urandom;
                1:       m = $urandom & $urandom & $urandom;
                2:       m = 32'd1 << $urandom_range(0, 31);
                default: m = $urandom & $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_mask(m, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a five-index sequence.
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_mask  = 32'h0000_01F0;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.idx_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("mid.count", 32'(bus.count), 32'd3);
        check("mid.idx",   32'(bus.idx),   32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        bus.idx_ready = 1'b0;
        rst_n         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after_reset.done",      32'(bus.done),      32'd0);
            check("after_reset.idx_valid", 32'(bus.idx_valid), 32'd0);
        end
        run_mask(32'h0000_0050, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
